mult_tc_arbiter: RTL

MULT_TC_ARBITER -- requirements
Module: mult_tc_arbiter

---
 rtl/mult_tc_arbiter_if.sv | 23 ++
 rtl/mult_tc_arbiter.sv | 66 ++++++
 2 files changed

// File: rtl/mult_tc_arbiter_if.sv
// mult_tc_arbiter_if: requester and result handshake bundle for the shared multiplier
interface mult_tc_arbiter_if #(
   parameter int a_width = 8,
   parameter int b_width = 8
);
   logic [3:0] req_valid;
   logic [3:0] req_ready;
   logic [4*a_width-1:0] req_a;
   logic [4*b_width-1:0] req_b;
   logic res_valid;
   logic res_ready;
   logic [1:0] res_id;
   logic [a_width+b_width-1:0] res_product;
   logic busy;
   modport master (
      output req_valid, req_a, req_b, res_ready,
      input req_ready, res_valid, res_id, res_product, busy
   );
   modport slave (
      input req_valid, req_a, req_b, res_ready,
      output req_ready, res_valid, res_id, res_product, busy
   );
endinterface

// File: rtl/mult_tc_arbiter.sv
// mult_tc_arbiter: one signed multiplier shared round-robin by four requesters, 2-stage pipeline
module mult_tc_arbiter #(
   parameter int a_width = 8,
   parameter int b_width = 8
) (
   input logic clk,
   input logic rst,
   mult_tc_arbiter_if.slave bus
);
   localparam int pw = a_width + b_width;
   logic [1:0] ptr, gnt_id, s1_id, s2_id;
   logic found, s1_v, s2_v, s2_load, s1_take, accept;
   logic [a_width-1:0] s1_a;
   logic [b_width-1:0] s1_b;
   logic [pw-1:0] s2_p, ext_a, ext_b;
   assign s2_load = !s2_v || bus.res_ready;
   assign s1_take = !s1_v || s2_load;
   // round-robin search from ptr upward; first asserted requester wins
   always_comb begin
      found = 1'b0;
      gnt_id = 2'd0;
      for (int k = 0; k < 4; k++) begin
         if (!found && bus.req_valid[ptr + 2'(k)]) begin
            found = 1'b1;
            gnt_id = ptr + 2'(k);
         end
      end
   end
   assign accept = found && s1_take && !rst;
   assign bus.req_ready = accept ? 4'b0001 << gnt_id : 4'b0000;
   // sign-extend to full product width so the low bits are the exact signed product
   assign ext_a = {{b_width{s1_a[a_width-1]}}, s1_a};
   assign ext_b = {{a_width{s1_b[b_width-1]}}, s1_b};
   // S1 refills when empty or advancing; S2 loads when free or its result drains
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
         s1_v <= 1'b0;
         s1_a <= '0;
         s1_b <= '0;
         s1_id <= '0;
         s2_v <= 1'b0;
         s2_id <= '0;
         s2_p <= '0;
      end else begin
         if (s1_take) s1_v <= accept;
         if (accept) begin
            s1_a <= bus.req_a[gnt_id*a_width +: a_width];
            s1_b <= bus.req_b[gnt_id*b_width +: b_width];
            s1_id <= gnt_id;
            ptr <= gnt_id + 2'd1;
         end
         if (s2_load) begin
            s2_v <= s1_v;
            if (s1_v) begin
               s2_id <= s1_id;
               s2_p <= ext_a * ext_b;
            end
         end
      end
   end
   assign bus.res_valid = s2_v;
   assign bus.res_id = s2_id;
   assign bus.res_product = s2_p;
   assign bus.busy = s1_v | s2_v;
endmodule
